nak_loss_parser: RTL

- Upstream feeder of the sender loss list.
- Consumes the loss-information payload of a received UDT NAK control packet as a stream of 32-bit words.
- Decodes single-sequence and range encodings into (start, end) pairs.
- Drives them into the loss list's insert handshake one pair at a time, and flags malformed payloads.

---
 rtl/nak_loss_parser_pkg.sv | 23 ++
 rtl/nak_loss_parser_if.sv | 25 ++
 rtl/nak_loss_parser.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/nak_loss_parser_pkg.sv
// Shared UDT sequence-number definitions for the NAK parser and the loss lists.
package nak_loss_parser_pkg;

  localparam int unsigned SEQ_WIDTH     = 31;
  localparam int unsigned LOSS_FLAG_BIT = 31;
  localparam logic [31:0] SEQ_MASK      = 32'h7FFF_FFFF;
  localparam logic [31:0] DEF_MAX_SPAN  = 32'h0000_4000;

  typedef logic [SEQ_WIDTH-1:0] seq_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEnd  = 2'd1,
    StOut  = 2'd2,
    StDrop = 2'd3
  } nak_state_e;

  // Modular distance from start to stop; wrap-around is legal.
  function automatic seq_t seq_span(input seq_t start, input seq_t stop);
    return stop - start;
  endfunction

endpackage

// File: rtl/nak_loss_parser_if.sv
// NAK word stream plus loss-list insert handshake; master drives words, slave is the parser.
interface nak_loss_parser_if;

  logic [31:0] nak_data_i;
  logic        nak_valid_i;
  logic        nak_last_i;
  logic        nak_ready_o;
  logic [31:0] insert_start_o;
  logic [31:0] insert_end_o;
  logic        insert_valid_o;
  logic        insert_ready_i;
  logic        pkt_done_o;
  logic        err_o;

  modport master (
    output nak_data_i, nak_valid_i, nak_last_i, insert_ready_i,
    input  nak_ready_o, insert_start_o, insert_end_o, insert_valid_o, pkt_done_o, err_o
  );

  modport slave (
    input  nak_data_i, nak_valid_i, nak_last_i, insert_ready_i,
    output nak_ready_o, insert_start_o, insert_end_o, insert_valid_o, pkt_done_o, err_o
  );

endinterface

// File: rtl/nak_loss_parser.sv
// Decodes UDT NAK loss-info words into (start, end) pairs for the sender loss list.
// Optional NAK_STATS_EN adds saturating pair/error counters on stat_pairs_o/stat_errs_o.
module nak_loss_parser
  import nak_loss_parser_pkg::*;
#(
  parameter logic [31:0] MAX_SPAN = DEF_MAX_SPAN
) (
  input  logic               core_clk,
  input  logic               core_rst_n,
  nak_loss_parser_if.slave   bus,
  output logic [31:0]        stat_pairs_o,
  output logic [15:0]        stat_errs_o
);

  nak_state_e state_q, state_d;
  seq_t       start_q, start_d;
  seq_t       end_q, end_d;
  logic       last_q, last_d;
  logic       ready_q;

  logic accept;
  logic word_flag;
  logic word_last;
  seq_t word_seq;
  logic span_ok;
  logic handshake;
  logic err;
  logic done;

  assign accept    = bus.nak_valid_i && ready_q;
  assign word_flag = bus.nak_data_i[LOSS_FLAG_BIT];
  assign word_last = bus.nak_last_i;
  assign word_seq  = bus.nak_data_i[SEQ_WIDTH-1:0];
  assign span_ok   = ({1'b0, seq_span(start_q, word_seq)} <= MAX_SPAN);
  assign handshake = (state_q == StOut) && bus.insert_ready_i;

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    end_d   = end_q;
    last_d  = last_q;
    err     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!word_flag) begin
            start_d = word_seq;
            end_d   = word_seq;
            last_d  = word_last;
            state_d = StOut;
          end else if (!word_last) begin
            start_d = word_seq;
            state_d = StEnd;
          end else begin
            // Range opener with nothing after it.
            err  = 1'b1;
            done = 1'b1;
          end
        end
      end
      StEnd: begin
        if (accept) begin
          if (!word_flag && span_ok) begin
            end_d   = word_seq;
            last_d  = word_last;
            state_d = StOut;
          end else begin
            err = 1'b1;
            if (word_last) begin
              done    = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StDrop;
            end
          end
        end
      end
      StOut: begin
        if (handshake) begin
          done    = last_q;
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (accept && word_last) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ready is registered from the next state so it reads 0 during reset and never
  // depends combinationally on insert_ready_i.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q <= StIdle;
      start_q <= '0;
      end_q   <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      last_q  <= last_d;
      ready_q <= (state_d != StOut);
    end
  end

  assign bus.nak_ready_o    = ready_q;
  assign bus.insert_valid_o = (state_q == StOut);
  assign bus.insert_start_o = {1'b0, start_q};
  assign bus.insert_end_o   = {1'b0, end_q};
  assign bus.pkt_done_o     = done;
  assign bus.err_o          = err;

`ifdef NAK_STATS_EN
  logic [31:0] pairs_q;
  logic [15:0] errs_q;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      pairs_q <= '0;
      errs_q  <= '0;
    end else begin
      if (handshake && (pairs_q != '1)) pairs_q <= pairs_q + 32'd1;
      if (err && (errs_q != '1))        errs_q  <= errs_q + 16'd1;
    end
  end

  assign stat_pairs_o = pairs_q;
  assign stat_errs_o  = errs_q;
`else
  assign stat_pairs_o = '0;
  assign stat_errs_o  = '0;
`endif

endmodule
